// File: rtl/i2c_transaction_scheduler.sv
// Purpose: round-robin arbiter granting one of two requesters the shared I2C controller, with watchdog and bus-free gap.
// Latency: grant and Go one cycle after a request is sampled in IDLE; done pulse one cycle after I2CDone (or watchdog expiry).
// Backpressure: requests are levels held until the matching done pulse; a new grant waits for the gap to elapse.
module i2c_transaction_scheduler #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic       ReqA,
    input  logic       ReqB,
    input  logic [6:0] AddrA,
    input  logic [6:0] AddrB,
    input  logic       RWA,
    input  logic       RWB,
    input  logic [7:0] WDataA,
    input  logic [7:0] WDataB,
    input  logic       I2CDone,
    input  logic       I2CAckError,
    input  logic [7:0] I2CReadData,
    output logic       Go,
    output logic [6:0] SlaveAddr,
    output logic       ReadOrWrite,
    output logic [7:0] WriteData,
    output logic       GrantA,
    output logic       GrantB,
    output logic       DoneA,
    output logic       DoneB,
    output logic [7:0] RDataOut,
    output logic       Error,
    output logic       TimeOutFlag
);

    // Counters only need to reach their terminal value (N-1).
    localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_FINISH = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t             state;
    logic               last_b;    // 1: B was the most recent owner
    logic               owner_b;   // 1: B owns the current transaction
    logic [WD_W-1:0]    wd_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               pick_b;

    // B wins when it is the only requester, or on a tie when A was served last.
    assign pick_b = ReqB && (!ReqA || !last_b);

    // Scheduler FSM with all handshake and datapath outputs registered.
    always_ff @(posedge clock) begin
        if (Reset) begin
            state       <= S_IDLE;
            last_b      <= 1'b1;
            owner_b     <= 1'b0;
            wd_cnt      <= '0;
            gap_cnt     <= '0;
            Go          <= 1'b0;
            SlaveAddr   <= 7'h00;
            ReadOrWrite <= 1'b0;
            WriteData   <= 8'h00;
            GrantA      <= 1'b0;
            GrantB      <= 1'b0;
            DoneA       <= 1'b0;
            DoneB       <= 1'b0;
            RDataOut    <= 8'h00;
            Error       <= 1'b0;
            TimeOutFlag <= 1'b0;
        end else begin
            DoneA <= 1'b0;
            DoneB <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ReqA || ReqB) begin
                        owner_b     <= pick_b;
                        GrantA      <= !pick_b;
                        GrantB      <= pick_b;
                        Go          <= 1'b1;
                        SlaveAddr   <= pick_b ? AddrB : AddrA;
                        ReadOrWrite <= pick_b ? RWB : RWA;
                        WriteData   <= pick_b ? WDataB : WDataA;
                        wd_cnt      <= '0;
                        state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A completion on the terminal watchdog cycle still counts as a normal finish.
                    if (I2CDone || (wd_cnt == WD_LAST)) begin
                        if (I2CDone) begin
                            RDataOut <= I2CReadData;
                            Error    <= I2CAckError;
                        end else begin
                            RDataOut    <= 8'h00;
                            Error       <= 1'b1;
                            TimeOutFlag <= 1'b1;
                        end
                        Go     <= 1'b0;
                        GrantA <= 1'b0;
                        GrantB <= 1'b0;
                        DoneA  <= !owner_b;
                        DoneB  <= owner_b;
                        state  <= S_FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    last_b  <= owner_b;
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_transaction_scheduler.sv
module tb_i2c_transaction_scheduler;

    localparam int GAP = 4;
    localparam int TO  = 64;

    logic       clock = 1'b0;
    logic       Reset, ReqA, ReqB, RWA, RWB, I2CDone, I2CAckError;
    logic [6:0] AddrA, AddrB;
    logic [7:0] WDataA, WDataB, I2CReadData;
    logic       Go, ReadOrWrite, GrantA, GrantB, DoneA, DoneB, Error, TimeOutFlag;
    logic [6:0] SlaveAddr;
    logic [7:0] WriteData, RDataOut;

    int checks = 0;
    int fails  = 0;

    // Reference model state: who was served last, and the sticky timeout record.
    bit m_last_b;
    bit m_tof;

    i2c_transaction_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .Reset(Reset), .ReqA(ReqA), .ReqB(ReqB),
        .AddrA(AddrA), .AddrB(AddrB), .RWA(RWA), .RWB(RWB),
        .WDataA(WDataA), .WDataB(WDataB), .I2CDone(I2CDone),
        .I2CAckError(I2CAckError), .I2CReadData(I2CReadData),
        .Go(Go), .SlaveAddr(SlaveAddr), .ReadOrWrite(ReadOrWrite),
        .WriteData(WriteData), .GrantA(GrantA), .GrantB(GrantB),
        .DoneA(DoneA), .DoneB(DoneB), .RDataOut(RDataOut),
        .Error(Error), .TimeOutFlag(TimeOutFlag)
    );

    always #5 clock = ~clock;

    // Grants must never overlap.
    always @(negedge clock) begin
        if (Reset === 1'b0) begin
            checks++;
            if ((GrantA & GrantB) === 1'b1) begin
                fails++;
                $display("FAIL grant_exclusive: GrantA=%b GrantB=%b required not both 1", GrantA, GrantB);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        checks++;
        if ({Go, GrantA, GrantB, DoneA, DoneB, Error, TimeOutFlag} !== 7'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b required 0", {Go, GrantA, GrantB, DoneA, DoneB, Error, TimeOutFlag});
        end
        checks++;
        if ({RDataOut, SlaveAddr, ReadOrWrite, WriteData} !== 24'h0) begin
            fails++;
            $display("FAIL reset_data: got %h required 0", {RDataOut, SlaveAddr, ReadOrWrite, WriteData});
        end
        Reset = 1'b0;
        m_last_b = 1'b1;
        m_tof = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        bit expb;
        bit bad;
        ReqA = 1'b1; AddrA = 7'h11; RWA = 1'b1; WDataA = 8'h00;
        ReqB = 1'b1; AddrB = 7'h22; RWB = 1'b0; WDataB = 8'h77;
        tick();
        for (int k = 0; k < 3; k++) begin
            expb = (k == 1);
            checks++;
            if ({GrantA, GrantB, Go, SlaveAddr} !== {!expb, expb, 1'b1, (expb ? 7'h22 : 7'h11)}) begin
                fails++;
                $display("FAIL rr_grant[%0d]: got GA=%b GB=%b Go=%b addr=%h required GA=%b GB=%b Go=1",
                         k, GrantA, GrantB, Go, SlaveAddr, !expb, expb);
            end
            tick(); tick();
            I2CDone = 1'b1; I2CAckError = 1'b0; I2CReadData = 8'h10 + 8'(k);
            tick();
            I2CDone = 1'b0;
            checks++;
            if ({DoneA, DoneB, Go} !== {!expb, expb, 1'b0}) begin
                fails++;
                $display("FAIL rr_done[%0d]: got DA=%b DB=%b Go=%b required DA=%b DB=%b Go=0",
                         k, DoneA, DoneB, Go, !expb, expb);
            end
            if (k == 2) begin
                ReqA = 1'b0; ReqB = 1'b0;
            end
            bad = 1'b0;
            for (int i = 0; i < GAP + 1; i++) begin
                tick();
                if ({Go, GrantA, GrantB, DoneA, DoneB} !== 5'b0) bad = 1'b1;
            end
            checks++;
            if (bad !== 1'b0) begin
                fails++;
                $display("FAIL rr_gap[%0d]: handshake activity inside gap, got 1 required 0", k);
            end
            if (k < 2) tick();
        end
        m_last_b = 1'b0;
    endtask

    task automatic test_single_read();
        bit bad;
        ReqA = 1'b1; AddrA = 7'h48; RWA = 1'b1; WDataA = 8'($urandom);
        tick();
        checks++;
        if ({GrantA, GrantB, Go, SlaveAddr, ReadOrWrite} !== {1'b1, 1'b0, 1'b1, 7'h48, 1'b1}) begin
            fails++;
            $display("FAIL read_grant: got GA=%b Go=%b addr=%h rw=%b required 1 1 48 1",
                     GrantA, Go, SlaveAddr, ReadOrWrite);
        end
        bad = 1'b0;
        for (int i = 0; i < 19; i++) begin
            tick();
            if ({Go, GrantA, SlaveAddr, DoneA} !== {1'b1, 1'b1, 7'h48, 1'b0}) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL read_busy_stable: got unstable=1 required 0");
        end
        I2CDone = 1'b1; I2CAckError = 1'b0; I2CReadData = 8'hA5;
        tick();
        I2CDone = 1'b0; I2CReadData = 8'h3E;
        checks++;
        if ({DoneA, DoneB, Go, GrantA, RDataOut, Error} !== {1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0}) begin
            fails++;
            $display("FAIL read_done: got DA=%b DB=%b Go=%b GA=%b rd=%h err=%b required 1 0 0 0 a5 0",
                     DoneA, DoneB, Go, GrantA, RDataOut, Error);
        end
        ReqA = 1'b0;
        tick();
        checks++;
        if ({DoneA, RDataOut} !== {1'b0, 8'hA5}) begin
            fails++;
            $display("FAIL read_hold: got DA=%b rd=%h required 0 a5", DoneA, RDataOut);
        end
        for (int i = 0; i < GAP; i++) tick();
        m_last_b = 1'b0;
    endtask

    task automatic test_nack_write();
        bit bad;
        ReqB = 1'b1; AddrB = 7'h50; RWB = 1'b0; WDataB = 8'h3C;
        tick();
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if ({GrantB, Go, SlaveAddr, ReadOrWrite, WriteData} !== {1'b1, 1'b1, 7'h50, 1'b0, 8'h3C}) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL nack_busy_fields: got mismatch=1 required 0 (WriteData=%h)", WriteData);
        end
        I2CDone = 1'b1; I2CAckError = 1'b1; I2CReadData = 8'h00;
        tick();
        I2CDone = 1'b0; I2CAckError = 1'b0;
        checks++;
        if ({DoneB, DoneA, Error, TimeOutFlag, RDataOut} !== {1'b1, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            fails++;
            $display("FAIL nack_done: got DB=%b DA=%b err=%b tof=%b rd=%h required 1 0 1 0 00",
                     DoneB, DoneA, Error, TimeOutFlag, RDataOut);
        end
        ReqB = 1'b0;
        for (int i = 0; i < GAP + 1; i++) tick();
        m_last_b = 1'b1;
    endtask

    task automatic test_coincident_and_stray();
        bit bad;
        ReqA = 1'b1; AddrA = 7'h21; RWA = 1'b1;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        I2CDone = 1'b1; I2CAckError = 1'b0; I2CReadData = 8'h5A;
        tick();
        I2CDone = 1'b0;
        checks++;
        if ({DoneA, Error, TimeOutFlag, RDataOut} !== {1'b1, 1'b0, 1'b0, 8'h5A}) begin
            fails++;
            $display("FAIL coincident: got DA=%b err=%b tof=%b rd=%h required 1 0 0 5a",
                     DoneA, Error, TimeOutFlag, RDataOut);
        end
        ReqA = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < GAP + 1; i++) begin
            I2CDone = (i == 2); I2CAckError = 1'b1; I2CReadData = 8'hEE;
            tick();
            if (i > 0 && {DoneA, DoneB, RDataOut, Error} !== {1'b0, 1'b0, 8'h5A, 1'b0}) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL stray_gap: got reaction=1 required 0 (rd=%h)", RDataOut);
        end
        I2CDone = 1'b1;
        tick();
        I2CDone = 1'b0; I2CAckError = 1'b0;
        tick();
        checks++;
        if ({Go, DoneA, DoneB, RDataOut, Error} !== {1'b0, 1'b0, 1'b0, 8'h5A, 1'b0}) begin
            fails++;
            $display("FAIL stray_idle: got Go=%b DA=%b DB=%b rd=%h err=%b required 0 0 0 5a 0",
                     Go, DoneA, DoneB, RDataOut, Error);
        end
        m_last_b = 1'b0;
    endtask

    task automatic test_watchdog();
        bit bad;
        ReqA = 1'b1; AddrA = 7'h33; RWA = 1'b1;
        tick();
        bad = 1'b0;
        for (int i = 0; i < TO; i++) begin
            if ({Go, DoneA} !== 2'b10) bad = 1'b1;
            tick();
        end
        checks++;
        if (bad !== 1'b0) begin
            fails++;
            $display("FAIL wdog_busy: Go not held for %0d cycles, got 1 required 0", TO);
        end
        checks++;
        if ({DoneA, Go, Error, RDataOut, TimeOutFlag} !== {1'b1, 1'b0, 1'b1, 8'h00, 1'b1}) begin
            fails++;
            $display("FAIL wdog_done: got DA=%b Go=%b err=%b rd=%h tof=%b required 1 0 1 00 1",
                     DoneA, Go, Error, RDataOut, TimeOutFlag);
        end
        ReqA = 1'b0;
        for (int i = 0; i < GAP + 1; i++) tick();
        ReqB = 1'b1; AddrB = 7'h34; RWB = 1'b1;
        tick(); tick();
        I2CDone = 1'b1; I2CAckError = 1'b0; I2CReadData = 8'h99;
        tick();
        I2CDone = 1'b0;
        checks++;
        if ({DoneB, Error, RDataOut, TimeOutFlag} !== {1'b1, 1'b0, 8'h99, 1'b1}) begin
            fails++;
            $display("FAIL wdog_sticky: got DB=%b err=%b rd=%h tof=%b required 1 0 99 1",
                     DoneB, Error, RDataOut, TimeOutFlag);
        end
        ReqB = 1'b0;
        for (int i = 0; i < GAP + 1; i++) tick();
        m_last_b = 1'b1;
        m_tof = 1'b1;
    endtask

    task automatic test_reset_mid_busy();
        logic [6:0] ab;
        ReqA = 1'b1; AddrA = 7'h44; RWA = 1'b1; WDataA = 8'hF0;
        tick();
        for (int i = 0; i < 10; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0; ReqA = 1'b0;
        checks++;
        if ({Go, GrantA, GrantB, DoneA, DoneB, Error, TimeOutFlag, RDataOut, SlaveAddr, ReadOrWrite, WriteData} !== 31'h0) begin
            fails++;
            $display("FAIL rst_busy_outputs: got Go=%b GA=%b tof=%b addr=%h wd=%h required all 0",
                     Go, GrantA, TimeOutFlag, SlaveAddr, WriteData);
        end
        m_last_b = 1'b1;
        m_tof = 1'b0;
        I2CDone = 1'b1; I2CAckError = 1'b1; I2CReadData = 8'hCD;
        tick();
        I2CDone = 1'b0; I2CAckError = 1'b0;
        checks++;
        if ({Go, DoneA, DoneB, Error, RDataOut} !== 12'h0) begin
            fails++;
            $display("FAIL rst_late_done: got DA=%b DB=%b err=%b rd=%h required 0", DoneA, DoneB, Error, RDataOut);
        end
        ab = 7'($urandom);
        ReqB = 1'b1; AddrB = ab; RWB = 1'b0; WDataB = 8'h81;
        tick();
        checks++;
        if ({GrantB, GrantA, Go, SlaveAddr, WriteData} !== {1'b1, 1'b0, 1'b1, ab, 8'h81}) begin
            fails++;
            $display("FAIL rst_regrant: got GB=%b GA=%b Go=%b addr=%h wd=%h required 1 0 1 %h 81",
                     GrantB, GrantA, Go, SlaveAddr, WriteData, ab);
        end
        I2CDone = 1'b1; I2CReadData = 8'h00;
        tick();
        I2CDone = 1'b0;
        checks++;
        if ({DoneB, Error, TimeOutFlag} !== 3'b100) begin
            fails++;
            $display("FAIL rst_regrant_done: got DB=%b err=%b tof=%b required 1 0 0", DoneB, Error, TimeOutFlag);
        end
        ReqB = 1'b0;
        for (int i = 0; i < GAP + 1; i++) tick();
        m_last_b = 1'b1;
    endtask

    task automatic test_random();
        int         pat, dly;
        bit         wb, tmo, rw, ack, bad;
        logic [7:0] rd, exp_rd;
        for (int n = 0; n < 30; n++) begin
            pat = $urandom_range(0, 2);
            ReqA = (pat != 1); ReqB = (pat != 0);
            AddrA = 7'($urandom); AddrB = 7'($urandom);
            RWA = 1'($urandom); RWB = 1'($urandom);
            WDataA = 8'($urandom); WDataB = 8'($urandom);
            wb = (pat == 1) || (pat == 2 && !m_last_b);
            rw = wb ? RWB : RWA;
            tick();
            checks++;
            if ({GrantA, GrantB, Go, SlaveAddr, ReadOrWrite, WriteData} !==
                {!wb, wb, 1'b1, (wb ? AddrB : AddrA), rw, (wb ? WDataB : WDataA)}) begin
                fails++;
                $display("FAIL rnd_grant[%0d]: got GA=%b GB=%b addr=%h rw=%b wd=%h required GA=%b GB=%b",
                         n, GrantA, GrantB, SlaveAddr, ReadOrWrite, WriteData, !wb, wb);
            end
            if ($urandom_range(0, 3) == 0) begin
                ReqA = 1'b0; ReqB = 1'b0;
            end
            dly = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(1, 12);
            tmo = (dly > TO);
            ack = 1'($urandom);
            rd = rw ? 8'($urandom) : 8'h00;
            if (tmo) begin
                for (int i = 0; i < TO; i++) tick();
                exp_rd = 8'h00;
                m_tof = 1'b1;
            end else begin
                for (int i = 0; i < dly - 1; i++) tick();
                I2CDone = 1'b1; I2CAckError = ack; I2CReadData = rd;
                tick();
                I2CDone = 1'b0; I2CAckError = 1'b0;
                exp_rd = rd;
            end
            checks++;
            if ({DoneA, DoneB, Go, RDataOut, Error, TimeOutFlag} !==
                {!wb, wb, 1'b0, exp_rd, (tmo ? 1'b1 : ack), m_tof}) begin
                fails++;
                $display("FAIL rnd_done[%0d]: got DA=%b DB=%b Go=%b rd=%h err=%b tof=%b required DA=%b DB=%b rd=%h err=%b tof=%b",
                         n, DoneA, DoneB, Go, RDataOut, Error, TimeOutFlag, !wb, wb, exp_rd, (tmo ? 1'b1 : ack), m_tof);
            end
            m_last_b = wb;
            ReqA = 1'b0; ReqB = 1'b0;
            bad = 1'b0;
            for (int i = 0; i < GAP + 1; i++) begin
                I2CDone = ($urandom_range(0, 3) == 0); I2CReadData = 8'($urandom);
                tick();
                if ({Go, DoneA, DoneB, RDataOut} !== {3'b000, exp_rd}) bad = 1'b1;
            end
            I2CDone = 1'b0;
            checks++;
            if (bad !== 1'b0) begin
                fails++;
                $display("FAIL rnd_gap[%0d]: activity or data change in gap, got 1 required 0", n);
            end
        end
    endtask

    initial begin
        Reset = 1'b1; ReqA = 1'b0; ReqB = 1'b0; AddrA = '0; AddrB = '0;
        RWA = 1'b0; RWB = 1'b0; WDataA = '0; WDataB = '0;
        I2CDone = 1'b0; I2CAckError = 1'b0; I2CReadData = '0;
        tick();
        test_reset();
        test_round_robin();
        test_single_read();
        test_nack_write();
        test_coincident_and_stray();
        test_watchdog();
        test_reset_mid_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/i2c_transaction_scheduler.md
# i2c_transaction_scheduler

Arbitrates two independent requesters (periodic sensor poll engine and user/front-panel command path) for the single `I2C_Controller` plus shift-register datapath, one transaction at a time.

- Latches the winning request's slave address, direction and write byte.
- Drives `Go` to the controller and waits for the datapath's completion pulse.
- Returns read data and an error flag to the winner.
- Enforces a bus-free gap between transactions.
- Aborts hung transactions via a watchdog.

## Interface
Parameters:
- `GAP_CYCLES`, default 16: idle `clock` cycles between one transaction's completion and the next grant (minimum 1).
- `TIMEOUT_CYCLES`, default 4096: maximum `clock` cycles in BUSY before the watchdog aborts.

Ports:
- `clock`  in  1  system clock; the only clock.
- `Reset`  in  1  synchronous, active-high reset.
- `ReqA`, `ReqB`  in  1 each  request levels, held until the matching `DoneA`/`DoneB`.
- `AddrA`, `AddrB`  in  7 each  slave address per requester.
- `RWA`, `RWB`  in  1 each  direction: 1 = read, 0 = write.
- `WDataA`, `WDataB`  in  8 each  write byte.
- `I2CDone`  in  1  one-cycle pulse from the datapath at end of STOP.
- `I2CAckError`  in  1  datapath NACK flag, valid with `I2CDone`.
- `I2CReadData`  in  8  received byte, valid with `I2CDone`.
- `Go`  out  1  start request to `I2C_Controller`.
- `SlaveAddr`  out  7  latched address to the datapath.
- `ReadOrWrite`  out  1  latched direction.
- `WriteData`  out  8  latched write byte.
- `GrantA`, `GrantB`  out  1 each  owner indication; mutually exclusive.
- `DoneA`, `DoneB`  out  1 each  one-cycle completion pulse.
- `RDataOut`  out  8  read byte; valid with the done pulse, held until the next completion.
- `Error`  out  1  NACK or timeout; valid with the done pulse, held.
- `TimeOutFlag`  out  1  sticky; set on watchdog abort, cleared only by `Reset`.

## Operation
- **States:**
  - IDLE: arbitrates.
  - BUSY: `Go` asserted, waiting for `I2CDone`.
  - FINISH: one cycle; emits the done pulse.
  - GAP: counts `GAP_CYCLES`.
- **IDLE:**
  - If only one request is high, grant it.
  - If both are high, grant the requester not granted last (round robin).
  - `LastGrant` resets to B, so A wins the first tie.
  - On a grant: latch Addr/RW/WData into `SlaveAddr`/`ReadOrWrite`/`WriteData`, set the Grant output, then go to BUSY.
- **BUSY:**
  - `Go`=1 for every BUSY cycle; latched fields are stable throughout.
  - The watchdog counter increments each cycle.
  - `I2CDone`=1 → capture `I2CReadData` into `RDataOut` and `I2CAckError` into `Error`; go to FINISH.
  - Counter reaches `TIMEOUT_CYCLES`-1 without `I2CDone` → `RDataOut`=8'h00, `Error`=1, `TimeOutFlag`=1; go to FINISH.
- **FINISH:** `Go`=0, Grant=0, the owner's done pulse =1, update `LastGrant`, go to GAP.
- **GAP:** all handshake outputs 0; after `GAP_CYCLES` cycles go to IDLE.
- **Boundary conditions:**
  - Request dropped during BUSY: ignored; the transaction completes normally.
  - Request held high after its done pulse: treated as a new request in the next IDLE.
  - `I2CDone` in IDLE, FINISH or GAP: ignored; outputs unchanged.
  - `I2CDone` and timeout in the same cycle: `I2CDone` wins, no timeout recorded.
  - Write transactions: `RDataOut` is still overwritten with `I2CReadData` (the datapath drives 8'h00).
- **Reset**, at any state including mid-BUSY: at the next edge, state=IDLE; `Go`, Grants, Dones, `Error`, `TimeOutFlag` = 0; `RDataOut`, `SlaveAddr`, `WriteData` = 0; `ReadOrWrite`=0; `LastGrant`=B; counters = 0.

## Timing
- Request sampled high in IDLE at edge t → Grant and `Go` high from t+1.
- `I2CDone` sampled at edge d → `Go`/Grant low and done pulse high for cycle d+1 only.
- Next grant at the earliest at edge d+2+`GAP_CYCLES`.
- Timeout abort: done pulse at `TIMEOUT_CYCLES`+1 cycles after the grant edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single read:** `GAP_CYCLES`=4, `TIMEOUT_CYCLES`=64. `ReqA`=1, `AddrA`=7'h48, `RWA`=1; `I2CDone` pulsed 20 cycles after `Go` with `I2CReadData`=8'hA5 → required: `GrantA`/`Go` high 1 cycle after request; `SlaveAddr`=7'h48, `ReadOrWrite`=1; `DoneA` one cycle; `RDataOut`=8'hA5; `Error`=0.
- **Tie and round robin:** `ReqA`=`ReqB`=1 held → required: order A, B, A, with ≥4 idle cycles between each done pulse and the next `Go`; Grants never both high.
- **NACK on write:** B, `AddrB`=7'h50, `RWB`=0, `WDataB`=8'h3C; `I2CAckError`=1 with `I2CDone` → required: `WriteData`=8'h3C during BUSY; `DoneB` with `Error`=1; `TimeOutFlag`=0.
- **Watchdog:** no `I2CDone` → required: `Go` drops after 64 BUSY cycles; `DoneA`=1, `Error`=1, `RDataOut`=8'h00; `TimeOutFlag` stays 1 across later transactions.
- **Reset mid-BUSY:** `Reset` pulsed 10 cycles into BUSY → required: next edge all outputs 0; a late `I2CDone` is ignored; a subsequent `ReqB` is granted normally.
- **Stray and coincident events:** `I2CDone` pulsed in GAP → no done pulse. `I2CDone` on the exact timeout cycle → `Error`=`I2CAckError`, `TimeOutFlag`=0.
